// File: rtl/hwpe_stream_tcdm_fetcher_pkg.sv
// Shared types and constants for the TCDM fetcher: FSM state encoding and the
// fixed fields of a TCDM read request.
package hwpe_stream_tcdm_fetcher_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   // A read is wen=1 with every byte lane enabled and no write data.
   localparam logic TCDM_RD_WEN     = 1'b1;
   localparam logic TCDM_RD_BE_FILL = 1'b1;
   localparam logic TCDM_RD_DATA    = 1'b0;

endpackage

// File: rtl/hwpe_stream_fetcher_rsp_buf.sv
// Circular response buffer: strobes are written at grant time, data one cycle later
// at the same slot; a slot becomes visible only once its data has landed.
module hwpe_stream_fetcher_rsp_buf #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned NB_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  strb_push_i,
   input  logic [STRB_WIDTH-1:0] strb_i,
   input  logic                  dat_push_i,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic                  pop_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic [STRB_WIDTH-1:0] strb_o
);

   localparam int unsigned PW = $clog2(NB_OUTSTANDING);

   logic [PW-1:0] strb_wptr_q, strb_wptr_d;
   logic [PW:0]   dat_wptr_q, dat_wptr_d;
   logic [PW:0]   rptr_q, rptr_d;

   logic [NB_OUTSTANDING-1:0][DATA_WIDTH-1:0] dat_mem_q, dat_mem_d;
   logic [NB_OUTSTANDING-1:0][STRB_WIDTH-1:0] strb_mem_q, strb_mem_d;

   // The extra pointer bit separates full from empty on the data side.
   assign valid_o = (dat_wptr_q != rptr_q);
   assign dat_o   = valid_o ? dat_mem_q[rptr_q[PW-1:0]] : '0;
   assign strb_o  = valid_o ? strb_mem_q[rptr_q[PW-1:0]] : '0;

   always_comb begin
      strb_wptr_d = strb_wptr_q;
      dat_wptr_d  = dat_wptr_q;
      rptr_d      = rptr_q;
      dat_mem_d   = dat_mem_q;
      strb_mem_d  = strb_mem_q;
      if (clear_i) begin
         strb_wptr_d = '0;
         dat_wptr_d  = '0;
         rptr_d      = '0;
      end else begin
         if (strb_push_i) begin
            strb_mem_d[strb_wptr_q] = strb_i;
            strb_wptr_d             = strb_wptr_q + PW'(1);
         end
         if (dat_push_i) begin
            dat_mem_d[dat_wptr_q[PW-1:0]] = dat_i;
            dat_wptr_d                    = dat_wptr_q + (PW+1)'(1);
         end
         if (pop_i && valid_o) begin
            rptr_d = rptr_q + (PW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strb_wptr_q <= '0;
         dat_wptr_q  <= '0;
         rptr_q      <= '0;
         dat_mem_q   <= '0;
         strb_mem_q  <= '0;
      end else begin
         strb_wptr_q <= strb_wptr_d;
         dat_wptr_q  <= dat_wptr_d;
         rptr_q      <= rptr_d;
         dat_mem_q   <= dat_mem_d;
         strb_mem_q  <= strb_mem_d;
      end
   end

endmodule

// File: rtl/hwpe_stream_tcdm_fetcher.sv
// TCDM read engine: turns generator addresses into reads and streams the responses
// out in request order; outstanding words are bounded by a credit counter.
module hwpe_stream_tcdm_fetcher
   import hwpe_stream_tcdm_fetcher_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned NB_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  test_mode_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   output logic                  addrgen_enable_o,
   input  logic [31:0]           addrgen_addr_i,
   input  logic [STRB_WIDTH-1:0] addrgen_strb_i,
   input  logic                  addrgen_in_progress_i,
   output logic                  tcdm_req_o,
   input  logic                  tcdm_gnt_i,
   output logic [31:0]           tcdm_add_o,
   output logic                  tcdm_wen_o,
   output logic [STRB_WIDTH-1:0] tcdm_be_o,
   output logic [DATA_WIDTH-1:0] tcdm_data_o,
   input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
   input  logic                  tcdm_r_valid_i,
   output logic                  stream_valid_o,
   input  logic                  stream_ready_i,
   output logic [DATA_WIDTH-1:0] stream_data_o,
   output logic [STRB_WIDTH-1:0] stream_strb_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned CW = $clog2(NB_OUTSTANDING) + 1;

   fetch_state_e   state_q, state_d;
   logic [CW-1:0]  credits_q, credits_d;
   logic           drop_q, drop_d;
   logic           rsp_exp_q, rsp_exp_d;

   logic grant;
   logic pop;
   logic rsp_push;
   logic unused_test_mode;

   assign unused_test_mode = test_mode_i;

   assign tcdm_req_o       = (state_q == FETCH_RUN) && addrgen_in_progress_i
                             && (credits_q < CW'(NB_OUTSTANDING));
   assign grant            = tcdm_req_o && tcdm_gnt_i;
   assign addrgen_enable_o = grant;
   assign tcdm_add_o       = addrgen_addr_i;
   assign tcdm_wen_o       = TCDM_RD_WEN;
   assign tcdm_be_o        = {STRB_WIDTH{TCDM_RD_BE_FILL}};
   assign tcdm_data_o      = {DATA_WIDTH{TCDM_RD_DATA}};

   assign pop      = stream_valid_o && stream_ready_i;
   // Responses to grants issued around a clear belong to the aborted transfer.
   assign rsp_push = tcdm_r_valid_i && !drop_q && !clear_i;

   assign busy_o = (state_q != FETCH_IDLE);
   assign done_o = (state_q == FETCH_DRAIN) && (credits_q == '0) && !clear_i;

   always_comb begin
      state_d   = state_q;
      credits_d = credits_q;
      drop_d    = clear_i;
      rsp_exp_d = grant;
      if (clear_i) begin
         state_d   = FETCH_IDLE;
         credits_d = '0;
      end else begin
         unique case (state_q)
            FETCH_IDLE:  if (start_i)                state_d = FETCH_RUN;
            FETCH_RUN:   if (!addrgen_in_progress_i) state_d = FETCH_DRAIN;
            FETCH_DRAIN: if (credits_q == '0)        state_d = FETCH_IDLE;
            default:                                 state_d = FETCH_IDLE;
         endcase
         if (grant && !pop) begin
            credits_d = credits_q + CW'(1);
         end else if (!grant && pop) begin
            credits_d = credits_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= FETCH_IDLE;
         credits_q <= '0;
         drop_q    <= 1'b0;
         rsp_exp_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         credits_q <= credits_d;
         drop_q    <= drop_d;
         rsp_exp_q <= rsp_exp_d;
      end
   end

   hwpe_stream_fetcher_rsp_buf #(
      .DATA_WIDTH     ( DATA_WIDTH     ),
      .STRB_WIDTH     ( STRB_WIDTH     ),
      .NB_OUTSTANDING ( NB_OUTSTANDING )
   ) i_rsp_buf (
      .clk_i       ( clk_i          ),
      .rst_ni      ( rst_ni         ),
      .clear_i     ( clear_i        ),
      .strb_push_i ( grant          ),
      .strb_i      ( addrgen_strb_i ),
      .dat_push_i  ( rsp_push       ),
      .dat_i       ( tcdm_r_data_i  ),
      .pop_i       ( pop            ),
      .valid_o     ( stream_valid_o ),
      .dat_o       ( stream_data_o  ),
      .strb_o      ( stream_strb_o  )
   );

   rsp_without_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tcdm_r_valid_i |-> rsp_exp_q);

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetcher.sv
// Directed bench for hwpe_stream_tcdm_fetcher with a behavioural generator and TCDM.
module tb_hwpe_stream_tcdm_fetcher;

   logic        clk;
   logic        rst_n;
   logic        test_mode_i;
   logic        clear_i;
   logic        start_i;
   logic        addrgen_enable_o;
   logic [31:0] addrgen_addr_i;
   logic [3:0]  addrgen_strb_i;
   logic        addrgen_in_progress_i;
   logic        tcdm_req_o;
   logic        tcdm_gnt_i;
   logic [31:0] tcdm_add_o;
   logic        tcdm_wen_o;
   logic [3:0]  tcdm_be_o;
   logic [31:0] tcdm_data_o;
   logic [31:0] tcdm_r_data_i;
   logic        tcdm_r_valid_i;
   logic        stream_valid_o;
   logic        stream_ready_i;
   logic [31:0] stream_data_o;
   logic [3:0]  stream_strb_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   // Generator model state
   int          gen_cnt, gen_len, gen_en_cnt, gen_len_set;
   logic        gen_load;
   logic [31:0] gen_base;
   logic [3:0]  gen_first, gen_last;

   // Bench-side expectations for the current transfer
   int exp_idx;
   int grants;
   int seen_done;

   hwpe_stream_tcdm_fetcher #(.DATA_WIDTH(32), .STRB_WIDTH(4), .NB_OUTSTANDING(4)) dut (
      .clk_i                 ( clk                   ),
      .rst_ni                ( rst_n                 ),
      .test_mode_i           ( test_mode_i           ),
      .clear_i               ( clear_i               ),
      .start_i               ( start_i               ),
      .addrgen_enable_o      ( addrgen_enable_o      ),
      .addrgen_addr_i        ( addrgen_addr_i        ),
      .addrgen_strb_i        ( addrgen_strb_i        ),
      .addrgen_in_progress_i ( addrgen_in_progress_i ),
      .tcdm_req_o            ( tcdm_req_o            ),
      .tcdm_gnt_i            ( tcdm_gnt_i            ),
      .tcdm_add_o            ( tcdm_add_o            ),
      .tcdm_wen_o            ( tcdm_wen_o            ),
      .tcdm_be_o             ( tcdm_be_o             ),
      .tcdm_data_o           ( tcdm_data_o           ),
      .tcdm_r_data_i         ( tcdm_r_data_i         ),
      .tcdm_r_valid_i        ( tcdm_r_valid_i        ),
      .stream_valid_o        ( stream_valid_o        ),
      .stream_ready_i        ( stream_ready_i        ),
      .stream_data_o         ( stream_data_o         ),
      .stream_strb_o         ( stream_strb_o         ),
      .busy_o                ( busy_o                ),
      .done_o                ( done_o                )
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3C3_0000;
   endfunction

   function automatic logic [3:0] exp_strb(input int idx);
      if (idx == 0) return gen_first;
      if (idx == gen_len_set - 1) return gen_last;
      return 4'hF;
   endfunction

   assign addrgen_in_progress_i = (gen_cnt < gen_len);
   assign addrgen_addr_i        = gen_base + 32'(4 * gen_cnt);
   assign addrgen_strb_i        = (gen_cnt == 0) ? gen_first :
                                  (gen_cnt == gen_len - 1) ? gen_last : 4'hF;

   // Address generator and single-cycle-latency TCDM
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_cnt        <= 0;
         gen_len        <= 0;
         gen_en_cnt     <= 0;
         tcdm_r_valid_i <= 1'b0;
         tcdm_r_data_i  <= '0;
      end else begin
         if (gen_load) begin
            gen_cnt    <= 0;
            gen_len    <= gen_len_set;
            gen_en_cnt <= 0;
         end else if (addrgen_enable_o) begin
            gen_cnt    <= gen_cnt + 1;
            gen_en_cnt <= gen_en_cnt + 1;
         end
         tcdm_r_valid_i <= tcdm_req_o & tcdm_gnt_i;
         tcdm_r_data_i  <= mem_word(tcdm_add_o);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_gen(input int len, input logic [31:0] base,
                           input logic [3:0] first, input logic [3:0] last);
      @(negedge clk);
      gen_len_set = len;
      gen_base    = base;
      gen_first   = first;
      gen_last    = last;
      gen_load    = 1'b1;
      @(negedge clk);
      gen_load    = 1'b0;
      exp_idx     = 0;
   endtask

   // Runs with ready=1 until done_o, checking every word in order.
   task automatic collect(input string tag, input bit do_start, input bit alt_gnt, input int budget);
      logic        pend;
      logic [31:0] pend_addr;
      pend      = 1'b0;
      pend_addr = '0;
      seen_done = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         start_i        = do_start && (k == 0);
         tcdm_gnt_i     = alt_gnt ? k[0] : 1'b1;
         stream_ready_i = 1'b1;
         #1;
         if (pend) begin
            chk({tag, "_req_hold"}, tcdm_req_o, 1);
            chk({tag, "_add_hold"}, tcdm_add_o, pend_addr);
         end
         pend      = tcdm_req_o && !tcdm_gnt_i;
         pend_addr = tcdm_add_o;
         if (stream_valid_o) begin
            chk({tag, "_data"}, stream_data_o, mem_word(gen_base + 32'(4 * exp_idx)));
            chk({tag, "_strb"}, stream_strb_o, exp_strb(exp_idx));
            exp_idx++;
         end
         if (done_o) begin
            seen_done = 1;
            break;
         end
      end
      start_i = 1'b0;
      chk({tag, "_done_seen"}, seen_done, 1);
      chk({tag, "_words"}, exp_idx, gen_len_set);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n          = 1'b0;
      test_mode_i    = 1'b0;
      clear_i        = 1'b0;
      start_i        = 1'b0;
      tcdm_gnt_i     = 1'b0;
      stream_ready_i = 1'b0;
      gen_load       = 1'b0;
      gen_len_set    = 0;
      gen_base       = '0;
      gen_first      = 4'hF;
      gen_last       = 4'hF;
      exp_idx        = 0;
      grants         = 0;
      seen_done      = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req",   tcdm_req_o, 0);
      chk("rst_en",    addrgen_enable_o, 0);
      chk("rst_valid", stream_valid_o, 0);
      chk("rst_busy",  busy_o, 0);
      chk("rst_done",  done_o, 0);
      chk("rst_data",  stream_data_o, 0);
      chk("rst_strb",  stream_strb_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rd_wen",  tcdm_wen_o, 1);
      chk("rd_be",   tcdm_be_o, 4'hF);
      chk("rd_wdat", tcdm_data_o, 0);

      // 1: full-rate 8-word transfer, cycle-exact timing
      load_gen(8, 32'h0000_1000, 4'hF, 4'hF);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         start_i        = (k == 1);
         tcdm_gnt_i     = 1'b1;
         stream_ready_i = 1'b1;
         #1;
         chk("t1_req",  tcdm_req_o, (k >= 2 && k <= 9));
         chk("t1_vld",  stream_valid_o, (k >= 4 && k <= 11));
         chk("t1_done", done_o, (k == 12));
         if (tcdm_req_o) chk("t1_add", tcdm_add_o, 32'h0000_1000 + 32'(4 * (k - 2)));
         if (stream_valid_o) begin
            chk("t1_data", stream_data_o, mem_word(32'h0000_1000 + 32'(4 * exp_idx)));
            exp_idx++;
         end
      end
      start_i = 1'b0;
      chk("t1_words", exp_idx, 8);
      chk("t1_idle",  busy_o, 0);

      // 2: stream stalled, credits cap outstanding grants at 4
      load_gen(8, 32'h0000_2000, 4'hF, 4'hF);
      grants = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start_i        = (k == 1);
         tcdm_gnt_i     = 1'b1;
         stream_ready_i = 1'b0;
         #1;
         if (tcdm_req_o && tcdm_gnt_i) grants++;
      end
      start_i = 1'b0;
      chk("t2_grants", grants, 4);
      chk("t2_req",    tcdm_req_o, 0);
      chk("t2_en",     addrgen_enable_o, 0);
      chk("t2_vld",    stream_valid_o, 1);
      chk("t2_head",   stream_data_o, mem_word(32'h0000_2000));
      collect("t2", 1'b0, 1'b0, 60);

      // 3: grant on alternate cycles only
      load_gen(8, 32'h0000_3000, 4'hF, 4'hF);
      collect("t3", 1'b1, 1'b1, 80);
      chk("t3_enables", gen_en_cnt, 8);

      // 4: misaligned first/last strobes
      load_gen(8, 32'h0000_4002, 4'b1100, 4'b0011);
      collect("t4", 1'b1, 1'b0, 60);

      // 5: clear the cycle after a grant
      load_gen(8, 32'h0000_5000, 4'hF, 4'hF);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start_i        = (k == 1);
         clear_i        = (k == 3);
         tcdm_gnt_i     = 1'b1;
         stream_ready_i = 1'b0;
         #1;
         if (k >= 4) begin
            chk("t5_busy", busy_o, 0);
            chk("t5_vld",  stream_valid_o, 0);
            chk("t5_req",  tcdm_req_o, 0);
         end
      end
      start_i = 1'b0;
      clear_i = 1'b0;
      chk("t5_credits", dut.credits_q, 0);
      load_gen(4, 32'h0000_6000, 4'hF, 4'hF);
      collect("t5", 1'b1, 1'b0, 40);

      // 6: zero-length transfer
      load_gen(0, 32'h0000_7000, 4'hF, 4'hF);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start_i        = (k == 1);
         tcdm_gnt_i     = 1'b1;
         stream_ready_i = 1'b1;
         #1;
         chk("t6_req",  tcdm_req_o, 0);
         chk("t6_done", done_o, (k == 3));
         chk("t6_busy", busy_o, (k == 2 || k == 3));
      end

      // 6b: start pulse during RUN is ignored
      load_gen(8, 32'h0000_8000, 4'hF, 4'hF);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start_i        = (k == 1 || k == 3);
         tcdm_gnt_i     = 1'b1;
         stream_ready_i = 1'b1;
         #1;
      end
      start_i = 1'b0;
      collect("t6b", 1'b0, 1'b0, 40);
      @(negedge clk);
      #1;
      chk("t6b_idle", busy_o, 0);
      chk("t6b_done_once", done_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
